accelerator_port: RTL and testbench

//  Self-contained top-level accelerator port: internal ping-pong activation/weight GBF banks, a 32-lane MAC engine,
//  two partial-sum (psum) GBF banks, and a 4:1 lane-reduction read port.

---
 rtl/accelerator_port.sv | 225 ++++++++++++++++++++++
 tb/tb_accelerator_port.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/accelerator_port.sv
// accelerator_port
// Port-level accelerator wrapper. It holds ping-pong activation/weight GBF
// banks that an internal deterministic loader fills, a 32-lane MAC engine that
// accumulates K words per psum word, two psum GBF banks, and a 4:1
// lane-reduction read port that drains each psum bank after it is produced.
//
// Ports
//   clk                  in   rising-edge clock
//   reset                in   asynchronous reset, active low
//   actv_gbf1_need_data  out  activation bank 1 is being refilled
//   actv_gbf2_need_data  out  activation bank 2 is being refilled
//   wgt_gbf1_need_data   out  weight bank 1 is being refilled
//   wgt_gbf2_need_data   out  weight bank 2 is being refilled
//   reduced_r_data1b     out  reduced psum word drained from psum bank 1
//   reduced_r_data2b     out  reduced psum word drained from psum bank 2
//   r_en1b_out           out  reduced_r_data1b valid this cycle
//   r_en2b_out           out  reduced_r_data2b valid this cycle
module accelerator_port #(
  parameter int ROW                    = 16,
  parameter int COL                    = 16,
  parameter int IN_BITWIDTH            = 8,
  parameter int OUT_BITWIDTH           = 16,
  parameter int ACTV_ADDR_BITWIDTH     = 2,
  parameter int ACTV_DEPTH             = 4,
  parameter int WGT_ADDR_BITWIDTH      = 2,
  parameter int WGT_DEPTH              = 4,
  parameter int PSUM_ADDR_BITWIDTH     = 2,
  parameter int PSUM_DEPTH             = 4,
  parameter int GBF_DATA_BITWIDTH      = 256,
  parameter int GBF_ADDR_BITWIDTH      = 5,
  parameter int GBF_DEPTH              = 32,
  parameter int PSUM_GBF_DATA_BITWIDTH = 512,
  parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
  parameter int PSUM_GBF_DEPTH         = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  output logic                                actv_gbf1_need_data,
  output logic                                actv_gbf2_need_data,
  output logic                                wgt_gbf1_need_data,
  output logic                                wgt_gbf2_need_data,
  output logic [PSUM_GBF_DATA_BITWIDTH/4-1:0] reduced_r_data1b,
  output logic [PSUM_GBF_DATA_BITWIDTH/4-1:0] reduced_r_data2b,
  output logic                                r_en1b_out,
  output logic                                r_en2b_out
);

  localparam int L    = GBF_DATA_BITWIDTH / IN_BITWIDTH;
  localparam int K    = ACTV_DEPTH;
  localparam int KB   = ACTV_ADDR_BITWIDTH;
  localparam int NGRP = GBF_DEPTH / K;
  localparam int RL   = L / 4;
  localparam int CW   = GBF_ADDR_BITWIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_P0   = 2'd1;
  localparam logic [1:0] S_A    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

  localparam logic [CW-1:0] LAST_CNT  = CW'(GBF_DEPTH - 1);
  localparam logic [CW:0]   NGRP_CNT  = (CW + 1)'(NGRP);
  localparam logic [KB-1:0] GRP_LAST  = KB'(K - 1);

  // Geometry sanity check at elaboration; the reserved parameters are only
  // checked for consistency, they do not shape any logic.
  if (L * IN_BITWIDTH != GBF_DATA_BITWIDTH ||
      L * OUT_BITWIDTH != PSUM_GBF_DATA_BITWIDTH ||
      (L % 4) != 0 || (GBF_DEPTH % K) != 0 || NGRP > PSUM_GBF_DEPTH ||
      ROW < 1 || COL < 1 || WGT_DEPTH != (1 << WGT_ADDR_BITWIDTH) ||
      PSUM_DEPTH != (1 << PSUM_ADDR_BITWIDTH) || K != (1 << KB)) begin : g_badGeometry
    $error("accelerator_port: inconsistent geometry parameters");
  end

  logic [1:0]                         r_state;
  logic [CW-1:0]                      r_cnt;
  logic [7:0]                         r_fill;
  logic                               r_seenB;
  logic [OUT_BITWIDTH-1:0]            r_acc [L];

  logic [GBF_DATA_BITWIDTH-1:0]       r_actv1 [GBF_DEPTH];
  logic [GBF_DATA_BITWIDTH-1:0]       r_actv2 [GBF_DEPTH];
  logic [GBF_DATA_BITWIDTH-1:0]       r_wgt1  [GBF_DEPTH];
  logic [GBF_DATA_BITWIDTH-1:0]       r_wgt2  [GBF_DEPTH];
  logic [PSUM_GBF_DATA_BITWIDTH-1:0]  r_psum1 [PSUM_GBF_DEPTH];
  logic [PSUM_GBF_DATA_BITWIDTH-1:0]  r_psum2 [PSUM_GBF_DEPTH];

  logic [1:0]                         w_nextState;
  logic [CW-1:0]                      w_nextCnt;
  logic                               w_fill1, w_fill2;
  logic [GBF_DATA_BITWIDTH-1:0]       w_ldActv, w_ldWgt;
  logic [GBF_DATA_BITWIDTH-1:0]       w_macActv, w_macWgt;
  logic                               w_grpStart, w_grpEnd;
  logic                               w_psumWr1, w_psumWr2;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0]  w_psumAddr;
  logic [OUT_BITWIDTH-1:0]            w_prod    [L];
  logic [OUT_BITWIDTH-1:0]            w_accNext [L];
  logic [PSUM_GBF_DATA_BITWIDTH-1:0]  w_psumWord;
  logic                               w_drain1, w_drain2;
  logic [PSUM_GBF_ADDR_BITWIDTH-1:0]  w_drainAddr;
  logic [PSUM_GBF_DATA_BITWIDTH-1:0]  w_drainWord1, w_drainWord2;
  logic [PSUM_GBF_DATA_BITWIDTH/4-1:0] w_red1, w_red2;

  // Phase sequencer: one IDLE cycle, then P0 once, then A/B alternating,
  // each phase lasting GBF_DEPTH cycles as counted by r_cnt.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    if (r_state == S_IDLE) begin
      w_nextState = S_P0;
      w_nextCnt   = '0;
    end else if (r_cnt == LAST_CNT) begin
      w_nextState = (r_state == S_A) ? S_B : S_A;
      w_nextCnt   = '0;
    end else begin
      w_nextCnt   = r_cnt + 1'b1;
    end
  end

  // Loader: pair 1 is refilled in P0 and B, pair 2 in A. Activation lanes
  // follow (address + lane) mod 16, weight lanes carry (fill pass + 1) mod 16.
  always_comb begin
    w_fill1  = (r_state == S_P0) || (r_state == S_B);
    w_fill2  = (r_state == S_A);
    w_ldActv = '0;
    w_ldWgt  = '0;
    for (int i = 0; i < L; i++) begin
      w_ldActv[i*IN_BITWIDTH +: IN_BITWIDTH] = IN_BITWIDTH'((32'(r_cnt) + 32'(i)) % 32'd16);
      w_ldWgt[i*IN_BITWIDTH +: IN_BITWIDTH]  = IN_BITWIDTH'((r_fill + 8'd1) & 8'h0F);
    end
  end

  // MAC datapath: the pair not being refilled is consumed at the same address
  // the loader is writing into the other pair. Operands are sign-extended to
  // the psum width so the low product bits are the wrapped signed product.
  always_comb begin
    w_macActv  = (r_state == S_B) ? r_actv2[r_cnt] : r_actv1[r_cnt];
    w_macWgt   = (r_state == S_B) ? r_wgt2[r_cnt]  : r_wgt1[r_cnt];
    w_grpStart = (r_cnt[KB-1:0] == '0);
    w_grpEnd   = (r_cnt[KB-1:0] == GRP_LAST);
    w_psumWr1  = (r_state == S_A) && w_grpEnd;
    w_psumWr2  = (r_state == S_B) && w_grpEnd;
    w_psumAddr = PSUM_GBF_ADDR_BITWIDTH'(r_cnt >> KB);
    w_psumWord = '0;
    for (int i = 0; i < L; i++) begin
      w_prod[i] = {{(OUT_BITWIDTH-IN_BITWIDTH){w_macActv[i*IN_BITWIDTH+IN_BITWIDTH-1]}},
                   w_macActv[i*IN_BITWIDTH +: IN_BITWIDTH]} *
                  {{(OUT_BITWIDTH-IN_BITWIDTH){w_macWgt[i*IN_BITWIDTH+IN_BITWIDTH-1]}},
                   w_macWgt[i*IN_BITWIDTH +: IN_BITWIDTH]};
      w_accNext[i] = (w_grpStart ? '0 : r_acc[i]) + w_prod[i];
      w_psumWord[i*OUT_BITWIDTH +: OUT_BITWIDTH] = w_accNext[i];
    end
  end

  // Drain read port looks one cycle ahead so the registered output is valid
  // in the first GBF_DEPTH/K cycles of the draining phase. The first A phase
  // has no bank-2 psums yet, hence the r_seenB qualifier.
  always_comb begin
    w_drain1     = (w_nextState == S_B) && ({1'b0, w_nextCnt} < NGRP_CNT);
    w_drain2     = (w_nextState == S_A) && r_seenB && ({1'b0, w_nextCnt} < NGRP_CNT);
    w_drainAddr  = PSUM_GBF_ADDR_BITWIDTH'(w_nextCnt);
    w_drainWord1 = r_psum1[w_drainAddr];
    w_drainWord2 = r_psum2[w_drainAddr];
    w_red1       = '0;
    w_red2       = '0;
    for (int j = 0; j < RL; j++) begin
      w_red1[j*OUT_BITWIDTH +: OUT_BITWIDTH] =
        w_drainWord1[(4*j+0)*OUT_BITWIDTH +: OUT_BITWIDTH] + w_drainWord1[(4*j+1)*OUT_BITWIDTH +: OUT_BITWIDTH] +
        w_drainWord1[(4*j+2)*OUT_BITWIDTH +: OUT_BITWIDTH] + w_drainWord1[(4*j+3)*OUT_BITWIDTH +: OUT_BITWIDTH];
      w_red2[j*OUT_BITWIDTH +: OUT_BITWIDTH] =
        w_drainWord2[(4*j+0)*OUT_BITWIDTH +: OUT_BITWIDTH] + w_drainWord2[(4*j+1)*OUT_BITWIDTH +: OUT_BITWIDTH] +
        w_drainWord2[(4*j+2)*OUT_BITWIDTH +: OUT_BITWIDTH] + w_drainWord2[(4*j+3)*OUT_BITWIDTH +: OUT_BITWIDTH];
    end
  end

  // Bank storage; contents are not reset, only the control around them is.
  always_ff @(posedge clk) begin
    if (w_fill1) begin
      r_actv1[r_cnt] <= w_ldActv;
      r_wgt1[r_cnt]  <= w_ldWgt;
    end
    if (w_fill2) begin
      r_actv2[r_cnt] <= w_ldActv;
      r_wgt2[r_cnt]  <= w_ldWgt;
    end
    if (w_psumWr1) r_psum1[w_psumAddr] <= w_psumWord;
    if (w_psumWr2) r_psum2[w_psumAddr] <= w_psumWord;
  end

  // Control, accumulators and registered outputs. need_data is derived from
  // the next phase so it rises in the first fill cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state             <= S_IDLE;
      r_cnt               <= '0;
      r_fill              <= '0;
      r_seenB             <= 1'b0;
      for (int i = 0; i < L; i++) r_acc[i] <= '0;
      actv_gbf1_need_data <= 1'b0;
      actv_gbf2_need_data <= 1'b0;
      wgt_gbf1_need_data  <= 1'b0;
      wgt_gbf2_need_data  <= 1'b0;
      reduced_r_data1b    <= '0;
      reduced_r_data2b    <= '0;
      r_en1b_out          <= 1'b0;
      r_en2b_out          <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      if (r_state != S_IDLE && r_cnt == LAST_CNT) r_fill <= r_fill + 8'd1;
      if (r_state == S_B) r_seenB <= 1'b1;
      if (r_state == S_A || r_state == S_B) begin
        for (int i = 0; i < L; i++) r_acc[i] <= w_accNext[i];
      end
      actv_gbf1_need_data <= (w_nextState == S_P0) || (w_nextState == S_B);
      wgt_gbf1_need_data  <= (w_nextState == S_P0) || (w_nextState == S_B);
      actv_gbf2_need_data <= (w_nextState == S_A);
      wgt_gbf2_need_data  <= (w_nextState == S_A);
      r_en1b_out <= w_drain1;
      r_en2b_out <= w_drain2;
      if (w_drain1) reduced_r_data1b <= w_red1;
      if (w_drain2) reduced_r_data2b <= w_red2;
    end
  end

endmodule

// File: tb/tb_accelerator_port.sv
// tb_accelerator_port
// Self-checking bench for accelerator_port. Expected reduced psum words are
// computed from the loader pattern and queued when reset is released; each
// word is popped when the DUT raises the matching r_en. Phase-dependent
// need_data / r_en levels are checked every cycle against the phase timeline.
module tb_accelerator_port;

  logic         clk;
  logic         reset;
  logic         actv_gbf1_need_data;
  logic         actv_gbf2_need_data;
  logic         wgt_gbf1_need_data;
  logic         wgt_gbf2_need_data;
  logic [127:0] reduced_r_data1b;
  logic [127:0] reduced_r_data2b;
  logic         r_en1b_out;
  logic         r_en2b_out;

  int           checkCount = 0;
  int           errorCount = 0;
  int           cyc = 0;
  logic [127:0] q1 [$];
  logic [127:0] q2 [$];
  logic [127:0] last1;
  logic [127:0] last2;

  accelerator_port dut (
    .clk                 (clk),
    .reset               (reset),
    .actv_gbf1_need_data (actv_gbf1_need_data),
    .actv_gbf2_need_data (actv_gbf2_need_data),
    .wgt_gbf1_need_data  (wgt_gbf1_need_data),
    .wgt_gbf2_need_data  (wgt_gbf2_need_data),
    .reduced_r_data1b    (reduced_r_data1b),
    .reduced_r_data2b    (reduced_r_data2b),
    .r_en1b_out          (r_en1b_out),
    .r_en2b_out          (r_en2b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
    end
  endtask

  // Reduced word p of a drain whose source bank was filled in pass f:
  // lane j sums psum lanes 4j..4j+3, each the sum over words 4p..4p+3 of
  // ((a+i) mod 16) * ((f+1) mod 16).
  function automatic logic [127:0] expReduced(input int f, input int p);
    logic [127:0] r;
    int w;
    int s;
    r = '0;
    w = (f + 1) % 16;
    for (int j = 0; j < 8; j++) begin
      s = 0;
      for (int i = 4*j; i < 4*j + 4; i++)
        for (int a = 4*p; a < 4*p + 4; a++)
          s += ((a + i) % 16) * w;
      r[j*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  // Release reset and queue the drains expected over the next 300 cycles:
  // k-th bank-1 drain comes from fill pass 2k, k-th bank-2 drain from 2k+1.
  task automatic applyStimulus();
    q1.delete();
    q2.delete();
    last1 = '0;
    last2 = '0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 8; p++) begin
        q1.push_back(expReduced(2*k, p));
        q2.push_back(expReduced(2*k + 1, p));
      end
    end
    cyc   = 0;
    reset = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Need"}, {actv_gbf1_need_data, actv_gbf2_need_data, wgt_gbf1_need_data, wgt_gbf2_need_data}, 4'b0000);
    checkOutput({tag, "En"}, {r_en1b_out, r_en2b_out}, 2'b00);
    checkOutput({tag, "Data1"}, reduced_r_data1b, '0);
    checkOutput({tag, "Data2"}, reduced_r_data2b, '0);
  endtask

  // Advance one cycle and check all outputs at the falling edge.
  task automatic stepCycle();
    int phase;
    int slot;
    logic expNeed1, expNeed2, expEn1, expEn2;
    logic [127:0] exp;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    phase    = (cyc - 1) / 32;
    slot     = (cyc - 1) % 32;
    expNeed1 = (phase % 2) == 0;
    expNeed2 = (phase % 2) == 1;
    expEn1   = (phase >= 2) && ((phase % 2) == 0) && (slot < 8);
    expEn2   = (phase >= 3) && ((phase % 2) == 1) && (slot < 8);
    checkOutput("actvNeed1", actv_gbf1_need_data, expNeed1);
    checkOutput("wgtNeed1", wgt_gbf1_need_data, expNeed1);
    checkOutput("actvNeed2", actv_gbf2_need_data, expNeed2);
    checkOutput("wgtNeed2", wgt_gbf2_need_data, expNeed2);
    checkOutput("en1", r_en1b_out, expEn1);
    checkOutput("en2", r_en2b_out, expEn2);
    if (r_en1b_out) begin
      if (q1.size() > 0) exp = q1.pop_front();
      else exp = ~reduced_r_data1b;
      last1 = exp;
      checkOutput("data1", reduced_r_data1b, exp);
    end else begin
      checkOutput("hold1", reduced_r_data1b, last1);
    end
    if (r_en2b_out) begin
      if (q2.size() > 0) exp = q2.pop_front();
      else exp = ~reduced_r_data2b;
      last2 = exp;
      checkOutput("data2", reduced_r_data2b, exp);
    end else begin
      checkOutput("hold2", reduced_r_data2b, last2);
    end
  endtask

  // Power-on reset, partial run, asynchronous abort during a bank-1 drain in
  // phase B, then a full run that must reproduce the sequence from cycle 0.
  initial begin
    reset = 1'b0;
    #12;
    checkAllZero("rst");
    #8;
    applyStimulus();
    for (int n = 0; n < 131; n++) stepCycle();
    #2;
    reset = 1'b0;
    #1;
    checkAllZero("midRst");
    @(negedge clk);
    @(negedge clk);
    checkAllZero("midRstHeld");
    applyStimulus();
    for (int n = 0; n < 300; n++) stepCycle();
    checkOutput("q1Left", 128'(q1.size()), '0);
    checkOutput("q2Left", 128'(q2.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
